// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported unified memory between instruction fetch and data access.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module unified_mem_arbiter #(
   parameter int AW           = 16,
   parameter int DW           = 16,
   parameter int MEM_LAT      = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   input  logic          if_flush,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   // state | meaning
   // IDLE  | arbitrate, grant winner, capture its request
   // ISSUE | drive the memory strobe for one cycle
   // WAIT  | count down memory latency, return read data at zero
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   localparam logic [2:0] LAT_LOAD  = 3'(MEM_LAT - 1);
   localparam logic [2:0] STARVE_LIM = 3'(STARVE_LIMIT);

   state_t        state;
   logic          owner_d;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [2:0]    lat_cnt;
   logic          kill;

   logic idle, issue, resp;
   logic pick_i, pick_d;
   logic starve_hit;

`ifdef ARB_STARVE_GUARD_EN
   logic [2:0] starve_cnt;

   assign starve_hit = (starve_cnt == STARVE_LIM);

   always_ff @(posedge clk) begin
      if (rst)
         starve_cnt <= '0;
      else if (pick_i)
         starve_cnt <= '0;
      else if (pick_d && if_req)
         starve_cnt <= starve_cnt + 3'd1;
   end
`else
   // Limit is meaningless without the guard; strict data priority.
   assign starve_hit = (STARVE_LIM == 3'd0) && 1'b0;
`endif

   always_comb begin
      idle   = (state == IDLE) && !rst;
      issue  = (state == ISSUE) && !rst;
      resp   = (state == WAIT) && (lat_cnt == 3'd0) && !rst;
      pick_i = idle && if_req && (!d_req || starve_hit);
      pick_d = idle && d_req && !pick_i;
   end

   assign if_gnt    = pick_i;
   assign d_gnt     = pick_d;
   assign mem_en    = issue;
   assign mem_we    = issue && we_q;
   assign mem_addr  = issue ? addr_q : '0;
   assign mem_wdata = issue ? wdata_q : '0;

   // A flush arriving in the response cycle itself also suppresses the data.
   assign if_rvalid = resp && !owner_d && !kill && !if_flush;
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign d_rvalid  = (issue && we_q) || (resp && owner_d);
   assign d_rdata   = (resp && owner_d) ? mem_rdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         owner_d <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         lat_cnt <= '0;
         kill    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               kill <= 1'b0;
               if (pick_d) begin
                  owner_d <= 1'b1;
                  we_q    <= d_we;
                  addr_q  <= d_addr;
                  wdata_q <= d_wdata;
                  state   <= ISSUE;
               end else if (pick_i) begin
                  owner_d <= 1'b0;
                  we_q    <= 1'b0;
                  addr_q  <= if_addr;
                  wdata_q <= '0;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               if (!owner_d && if_flush)
                  kill <= 1'b1;
               if (we_q) begin
                  state <= IDLE;
               end else begin
                  lat_cnt <= LAT_LOAD;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (!owner_d && if_flush)
                  kill <= 1'b1;
               if (lat_cnt == 3'd0)
                  state <= IDLE;
               else
                  lat_cnt <= lat_cnt - 3'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed, table-driven bench for unified_mem_arbiter (MEM_LAT = 2).
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0, if_flush = 1'b0;
   logic [15:0] if_addr = '0;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [15:0] d_addr = '0, d_wdata = '0;
   logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
   logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [15:0] lat_addr = '0;

   unified_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: read data depends on the address captured at the strobe.
   always @(posedge clk) if (mem_en && !mem_we) lat_addr <= mem_addr;
   assign mem_rdata = (lat_addr == 16'h0010) ? 16'hBEEF : (lat_addr ^ 16'h5A5A);

   typedef struct {
      logic        r, ireq, fl, dreq, dwe;
      logic [15:0] ia, da, dw;
      logic [69:0] exp;
   } vec_t;

   vec_t vecs[64];
   int   nv = 0;
   int   nvec = 0;
   int   nfail = 0;

   task automatic add(input logic r, input logic ireq, input logic [15:0] ia, input logic fl,
                      input logic dreq, input logic dwe, input logic [15:0] da, input logic [15:0] dw,
                      input logic igt, input logic irv, input logic [15:0] ird,
                      input logic dgt, input logic drv, input logic [15:0] drd,
                      input logic men, input logic mwe, input logic [15:0] ma, input logic [15:0] mw);
      vecs[nv].r = r;   vecs[nv].ireq = ireq; vecs[nv].ia = ia; vecs[nv].fl = fl;
      vecs[nv].dreq = dreq; vecs[nv].dwe = dwe; vecs[nv].da = da; vecs[nv].dw = dw;
      vecs[nv].exp = {igt, irv, ird, dgt, drv, drd, men, mwe, ma, mw};
      nv++;
   endtask

   function automatic logic [69:0] outs();
      return {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we, mem_addr, mem_wdata};
   endfunction

   int ng_d, ng_i, nseq;
   logic [5:0] seq;

   initial begin
      //  r ireq ia      fl dreq dwe da       dw        igt irv ird      dgt drv drd      men mwe ma       mw
      add(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(1, 1, 16'h0010, 0, 1, 0, 16'h0300, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      // single fetch read
      add(0, 1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      // data writes, back to back every 2 cycles
      add(0, 0, 16'h0000, 0, 1, 1, 16'h0200, 16'h1234, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 1, 16'h0200, 16'h1234);
      add(0, 0, 16'h0000, 0, 1, 1, 16'h0202, 16'h5678, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 1, 16'h0202, 16'h5678);
      // contention: data read wins, fetch held and granted at T+4
      add(0, 1, 16'h0040, 0, 1, 0, 16'h0300, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(0, 1, 16'h0040, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0300, 16'h0000);
      add(0, 1, 16'h0040, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(0, 1, 16'h0040, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h595A, 0, 0, 16'h0000, 16'h0000);
      add(0, 1, 16'h0040, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0040, 16'h0000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h5A1A, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      // flush during WAIT kills the response; IDLE again at T+4
      add(0, 1, 16'h0080, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0080, 16'h0000);
      add(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(0, 0, 16'h0000, 0, 1, 1, 16'h0204, 16'h00AA, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 1, 16'h0204, 16'h00AA);
      // flush in IDLE is ignored, same-cycle fetch proceeds
      add(0, 1, 16'h0010, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      // reset in the middle of a data read: no late rvalid
      add(0, 0, 16'h0000, 0, 1, 0, 16'h0400, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0400, 16'h0000);
      add(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);

      for (int i = 0; i < nv; i++) begin
         @(negedge clk);
         rst = vecs[i].r;   if_req = vecs[i].ireq; if_addr = vecs[i].ia; if_flush = vecs[i].fl;
         d_req = vecs[i].dreq; d_we = vecs[i].dwe; d_addr = vecs[i].da; d_wdata = vecs[i].dw;
         #4;
         nvec++;
         if (outs() !== vecs[i].exp) begin
            nfail++;
            $display("FAIL vec%0d: got %h, expected %h", i, outs(), vecs[i].exp);
         end
      end

      // Both requesters held continuously (data writes, fetch reads).
      ng_d = 0; ng_i = 0; nseq = 0; seq = '0;
      @(negedge clk);
      if_req = 1'b1; if_addr = 16'h0100; if_flush = 1'b0;
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0500; d_wdata = 16'h0001;
      for (int c = 0; c < 40; c++) begin
         #4;
         if (if_gnt && d_gnt) begin
            nfail++;
            $display("FAIL dual_gnt: cycle %0d both grants high, expected at most one", c);
         end
         if (d_gnt || if_gnt) begin
            if (nseq < 6) seq[nseq] = d_gnt;
            nseq++;
         end
         if (d_gnt) ng_d++;
         if (if_gnt) ng_i++;
         @(negedge clk);
      end
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

`ifdef ARB_STARVE_GUARD_EN
      nvec++;
      if (seq !== 6'b101111) begin
         nfail++;
         $display("FAIL starve_seq: grant order %b (bit=1 data, lsb first), expected %b", seq, 6'b101111);
      end
      nvec++;
      if (ng_i < 1) begin
         nfail++;
         $display("FAIL starve_fetch: %0d fetch grants, expected at least 1", ng_i);
      end
`else
      nvec++;
      if (ng_i != 0) begin
         nfail++;
         $display("FAIL strict_fetch: %0d fetch grants, expected 0", ng_i);
      end
      nvec++;
      if (ng_d != 20) begin
         nfail++;
         $display("FAIL strict_data: %0d data grants, expected 20", ng_d);
      end
`endif

      repeat (8) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
